// File: rtl/obuf_rd_ctrl.sv
// Output-buffer read controller: walks the frame buffer in step with display
// requests and presents each pixel, RGB565 and RGB888, two enabled cycles later.
module obuf_rd_ctrl #(
    parameter int FRAME_PIXELS = 130560,
    parameter int ADDR_W       = 17
) (
    input  logic              iClk,
    input  logic              wRsn,
    input  logic              wEnClk,
    input  logic              wStCnn,
    input  logic              wDispDe,
    input  logic [15:0]       wOBufRdDt,
    output logic              wOBufRdEn,
    output logic [ADDR_W-1:0] wOBufRdAddr,
    output logic [15:0]       wPixRgb565,
    output logic [23:0]       wPixRgb888,
    output logic              wPixValid,
    output logic              wFrameDone,
    output logic              wRdBusy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_vld_p1_q, rd_vld_p1_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       pix_p2_q, pix_p2_d;
    logic              pix_vld_p2_q, pix_vld_p2_d;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;

    always_comb begin
        // wRsn gates the strobe so no read can escape while reset is held
        rd_en   = wRsn & wEnClk & wDispDe & ((state_q == ACTIVE) | wStCnn);
        rd_addr = wStCnn ? '0 : cnt_q;
        rd_last = (rd_addr == LAST_ADDR);

        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_vld_p1_d  = rd_vld_p1_q;
        frame_done_d = frame_done_q;
        pix_p2_d     = pix_p2_q;
        pix_vld_p2_d = pix_vld_p2_q;

        if (wEnClk) begin
            rd_vld_p1_d  = rd_en;
            frame_done_d = rd_en & rd_last;
            pix_vld_p2_d = rd_vld_p1_q;
            if (rd_vld_p1_q) begin
                pix_p2_d = wOBufRdDt;
            end

            if (rd_en) begin
                cnt_d = rd_last ? '0 : rd_addr + ADDR_W'(1);
            end else if (wStCnn) begin
                cnt_d = '0;
            end

            // Pipelined reads are never flushed; a restart only moves the counter
            unique case (state_q)
                IDLE, DONE: begin
                    if (rd_en && rd_last) state_d = DONE;
                    else if (wStCnn)      state_d = ACTIVE;
                end
                ACTIVE: begin
                    if (rd_en && rd_last) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge wRsn) begin
        if (!wRsn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_vld_p1_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pix_p2_q     <= '0;
            pix_vld_p2_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_vld_p1_q  <= rd_vld_p1_d;
            frame_done_q <= frame_done_d;
            pix_p2_q     <= pix_p2_d;
            pix_vld_p2_q <= pix_vld_p2_d;
        end
    end

    assign wOBufRdEn   = rd_en;
    assign wOBufRdAddr = rd_addr;
    assign wPixRgb565  = pix_p2_q;
    assign wPixRgb888  = {pix_p2_q[15:11], pix_p2_q[15:13],
                          pix_p2_q[10:5],  pix_p2_q[10:9],
                          pix_p2_q[4:0],   pix_p2_q[4:2]};
    assign wPixValid   = pix_vld_p2_q;
    assign wFrameDone  = frame_done_q;
    assign wRdBusy     = (state_q == ACTIVE);

endmodule
